// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - signal bundle between a command source, alu_cmd_issuer and the ALU
//
// Groups the three faces of the issuer into one interface:
//   command port  : cmd_valid/cmd_ready handshake with cmd_a, cmd_b, cmd_opcode, cmd_addr
//   ALU drive     : alu_a, alu_b, alu_opcode, alu_addr_in (issuer -> ALU)
//   ALU return    : alu_result, alu_addr_out (ALU -> issuer)
//   response port : rsp_valid/rsp_ready handshake with rsp_result, rsp_addr, rsp_err
//   status        : err_sticky, busy
// Modport master is the issuer's view; modport slave is the surrounding environment's view.
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_opcode;
  logic [ADDR_W-1:0] cmd_addr;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [ADDR_W-1:0] alu_addr_in;
  logic [RES_W-1:0]  alu_result;
  logic [ADDR_W-1:0] alu_addr_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  logic              err_sticky;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_addr,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_addr_in,
    input  alu_result, alu_addr_out,
    output rsp_valid, rsp_result, rsp_addr, rsp_err,
    input  rsp_ready,
    output err_sticky, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_addr,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_addr_in,
    output alu_result, alu_addr_out,
    input  rsp_valid, rsp_result, rsp_addr, rsp_err,
    output rsp_ready,
    input  err_sticky, busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - tagged command issuer and result collector for a fixed-latency ALU
//
// Buffers tagged commands, issues at most one per cycle to the ALU, follows each
// operation through the ALU latency with a valid/tag tracker, checks the returned
// tag and queues {result, expected tag, mismatch} for the response port.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; flushes all queues and the tracker
//   bus   : alu_cmd_issuer_if.master
//           cmd_*  command handshake and fields (cmd_ready is registered)
//           alu_*  registered ALU drive, plus the ALU result/tag return
//           rsp_*  response handshake and payload (rsp_addr is the expected tag)
//           err_sticky set on any tag mismatch, busy = work anywhere inside
//
// Depths must be powers of two and at least 2; ALU_LAT must be at least 1.
module alu_cmd_issuer #(
  parameter int DATA_W    = 8,
  parameter int RES_W     = 16,
  parameter int OP_W      = 3,
  parameter int ADDR_W    = 8,
  parameter int ALU_LAT   = 2,
  parameter int NOP_OP    = 0,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_cmd_issuer_if.master  bus
);

  // Tracker stage 0 is the issue register itself (same edge that loads alu_*);
  // the ALU presents its result while stage ALU_LAT is valid, which is where
  // capture happens.
  localparam int NSTG  = ALU_LAT + 1;
  localparam int CA_W  = $clog2(CMD_DEPTH);
  localparam int CC_W  = $clog2(CMD_DEPTH + 1);
  localparam int RA_W  = $clog2(RSP_DEPTH);
  localparam int RC_W  = $clog2(RSP_DEPTH + 1);
  localparam int CNT_W = $clog2(RSP_DEPTH + NSTG + 1) + 1;
  localparam logic [OP_W-1:0] NOP_V = OP_W'(NOP_OP);

  // Command FIFO
  logic [DATA_W-1:0] r_cq_a   [CMD_DEPTH];
  logic [DATA_W-1:0] r_cq_b   [CMD_DEPTH];
  logic [OP_W-1:0]   r_cq_op  [CMD_DEPTH];
  logic [ADDR_W-1:0] r_cq_tag [CMD_DEPTH];
  logic [CA_W-1:0]   r_cq_wr;
  logic [CA_W-1:0]   r_cq_rd;
  logic [CC_W-1:0]   r_cq_cnt;
  logic              r_cmd_ready;

  // ALU drive registers
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [ADDR_W-1:0] r_alu_tag;

  // Pipe tracker
  logic              r_pv   [NSTG];
  logic [ADDR_W-1:0] r_ptag [NSTG];

  // Response buffer
  logic [RES_W-1:0]  r_rb_res [RSP_DEPTH];
  logic [ADDR_W-1:0] r_rb_tag [RSP_DEPTH];
  logic              r_rb_err [RSP_DEPTH];
  logic [RA_W-1:0]   r_rb_wr;
  logic [RA_W-1:0]   r_rb_rd;
  logic [RC_W-1:0]   r_rb_cnt;
  logic              r_err_sticky;

  logic              w_push;
  logic              w_issue;
  logic              w_capture;
  logic              w_mismatch;
  logic              w_rsp_valid;
  logic              w_rsp_pop;
  logic [CNT_W-1:0]  w_inflight;
  logic [CNT_W-1:0]  w_used;
  logic [CC_W-1:0]   w_cq_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Handshake and credit decisions
  // ---------------------------------------------------------------------------
  assign w_push      = bus.cmd_valid && r_cmd_ready;
  assign w_rsp_valid = (r_rb_cnt != '0);
  assign w_rsp_pop   = w_rsp_valid && bus.rsp_ready;
  assign w_capture   = r_pv[NSTG-1];
  assign w_mismatch  = (bus.alu_addr_out != r_ptag[NSTG-1]);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < NSTG; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pv[i]);
    end
  end

  // Every issued op owns one response-buffer slot from issue until it is popped.
  // A same-cycle pop frees its slot immediately so a steady stream with
  // rsp_ready high keeps one issue per cycle. This only feeds the registered
  // alu_* drive, so it adds no input-to-output combinational path.
  assign w_used  = w_inflight + CNT_W'(r_rb_cnt) - CNT_W'(w_rsp_pop);
  assign w_issue = (r_cq_cnt != '0) && (w_used < CNT_W'(RSP_DEPTH));

  assign w_cq_cnt_nxt = r_cq_cnt + CC_W'(w_push) - CC_W'(w_issue);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cq_wr      <= '0;
      r_cq_rd      <= '0;
      r_cq_cnt     <= '0;
      r_cmd_ready  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= NOP_V;
      r_alu_tag    <= '0;
      for (int i = 0; i < NSTG; i++) begin
        r_pv[i]   <= 1'b0;
        r_ptag[i] <= '0;
      end
      r_rb_wr      <= '0;
      r_rb_rd      <= '0;
      r_rb_cnt     <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_cq_wr <= r_cq_wr + CA_W'(1);
      end
      if (w_issue) begin
        r_cq_rd <= r_cq_rd + CA_W'(1);
      end
      r_cq_cnt <= w_cq_cnt_nxt;
      // Ready is the registered "not full" of the next count, never a look-ahead
      // on an input.
      r_cmd_ready <= (w_cq_cnt_nxt != CC_W'(CMD_DEPTH));

      if (w_issue) begin
        r_alu_a   <= r_cq_a[r_cq_rd];
        r_alu_b   <= r_cq_b[r_cq_rd];
        r_alu_op  <= r_cq_op[r_cq_rd];
        r_alu_tag <= r_cq_tag[r_cq_rd];
      end else begin
        // Operands hold so idle cycles do not toggle the ALU datapath.
        r_alu_op  <= NOP_V;
        r_alu_tag <= '0;
      end

      r_pv[0]   <= w_issue;
      r_ptag[0] <= w_issue ? r_cq_tag[r_cq_rd] : '0;
      for (int i = 1; i < NSTG; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end

      if (w_capture) begin
        r_rb_wr <= r_rb_wr + RA_W'(1);
      end
      if (w_rsp_pop) begin
        r_rb_rd <= r_rb_rd + RA_W'(1);
      end
      r_rb_cnt <= r_rb_cnt + RC_W'(w_capture) - RC_W'(w_rsp_pop);

      if (w_capture && w_mismatch) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage (payload only, no reset needed: occupancy is tracked above)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cq_a[r_cq_wr]   <= bus.cmd_a;
      r_cq_b[r_cq_wr]   <= bus.cmd_b;
      r_cq_op[r_cq_wr]  <= bus.cmd_opcode;
      r_cq_tag[r_cq_wr] <= bus.cmd_addr;
    end
    if (w_capture) begin
      r_rb_res[r_rb_wr] <= bus.alu_result;
      r_rb_tag[r_rb_wr] <= r_ptag[NSTG-1];
      r_rb_err[r_rb_wr] <= w_mismatch;
    end
  end

  // The credit rule makes these impossible; they guard future edits.
  always_ff @(posedge clk) begin
    if (!reset && w_capture && !w_rsp_pop) begin
      assert (r_rb_cnt < RC_W'(RSP_DEPTH));
    end
    if (!reset && w_push && !w_issue) begin
      assert (r_cq_cnt < CC_W'(CMD_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_opcode  = r_alu_op;
  assign bus.alu_addr_in = r_alu_tag;

  // Payload is forced to zero while empty so stale entries never show.
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_result  = w_rsp_valid ? r_rb_res[r_rb_rd] : '0;
  assign bus.rsp_addr    = w_rsp_valid ? r_rb_tag[r_rb_rd] : '0;
  assign bus.rsp_err     = w_rsp_valid ? r_rb_err[r_rb_rd] : 1'b0;

  assign bus.err_sticky  = r_err_sticky;
  assign bus.busy        = (r_cq_cnt != '0) || (w_inflight != '0) || w_rsp_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
  localparam int DATA_W    = 8;
  localparam int RES_W     = 16;
  localparam int OP_W      = 3;
  localparam int ADDR_W    = 8;
  localparam int ALU_LAT   = 2;
  localparam int NOP_OP    = 0;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   i_cmd;
  int   n_rsp;
  int   issued;
  logic acc;

  logic [7:0] mm_tag    [3];
  logic       mm_err    [3];
  logic       mm_sticky [3];

  alu_cmd_issuer_if #(.DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) bus ();

  alu_cmd_issuer #(
    .DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .ADDR_W(ADDR_W),
    .ALU_LAT(ALU_LAT), .NOP_OP(NOP_OP), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU model: op 1 add, op 2 multiply, anything else concatenates; tag 0x22 comes back as 0x23.
  logic [RES_W-1:0]  m_res [ALU_LAT];
  logic [ADDR_W-1:0] m_tag [ALU_LAT];

  function automatic logic [RES_W-1:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return RES_W'(a) + RES_W'(b);
      3'd2:    return RES_W'(a) * RES_W'(b);
      default: return {a, b};
    endcase
  endfunction

  always @(posedge clk) begin
    m_res[0] <= alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
    m_tag[0] <= (bus.alu_addr_in == 8'h22) ? 8'h23 : bus.alu_addr_in;
    for (int k = 1; k < ALU_LAT; k++) begin
      m_res[k] <= m_res[k-1];
      m_tag[k] <= m_tag[k-1];
    end
  end

  assign bus.alu_result   = m_res[ALU_LAT-1];
  assign bus.alu_addr_out = m_tag[ALU_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] tag);
    bus.cmd_valid  = v;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_opcode = op;
    bus.cmd_addr   = tag;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_cmd_ready"},   32'(bus.cmd_ready),   0);
    chk({pfx, "_alu_a"},       32'(bus.alu_a),       0);
    chk({pfx, "_alu_b"},       32'(bus.alu_b),       0);
    chk({pfx, "_alu_opcode"},  32'(bus.alu_opcode),  NOP_OP);
    chk({pfx, "_alu_addr_in"}, 32'(bus.alu_addr_in), 0);
    chk({pfx, "_rsp_valid"},   32'(bus.rsp_valid),   0);
    chk({pfx, "_rsp_result"},  32'(bus.rsp_result),  0);
    chk({pfx, "_rsp_addr"},    32'(bus.rsp_addr),    0);
    chk({pfx, "_rsp_err"},     32'(bus.rsp_err),     0);
    chk({pfx, "_err_sticky"},  32'(bus.err_sticky),  0);
    chk({pfx, "_busy"},        32'(bus.busy),        0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    mm_tag    = '{8'h21, 8'h22, 8'h24};
    mm_err    = '{1'b0, 1'b1, 1'b0};
    mm_sticky = '{1'b0, 1'b1, 1'b1};
    repeat (2) tick();

    // Reset values
    chk_reset_values("rst");
    reset = 1'b0;
    chk("ready_before_edge", 32'(bus.cmd_ready), 0);
    tick();
    chk("ready_after_release", 32'(bus.cmd_ready), 1);

    // Single op: accept at E, alu_* at E+1, rsp_valid after E+4
    drive(1, 8'd3, 8'd5, 3'd1, 8'h11);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_not_yet_issued", 32'(bus.alu_opcode), NOP_OP);
    tick();
    chk("single_alu_op", 32'(bus.alu_opcode), 1);
    chk("single_alu_a", 32'(bus.alu_a), 3);
    chk("single_alu_b", 32'(bus.alu_b), 5);
    chk("single_alu_tag", 32'(bus.alu_addr_in), 'h11);
    tick();
    chk("single_nop_after", 32'(bus.alu_opcode), NOP_OP);
    chk("single_tag_zero", 32'(bus.alu_addr_in), 0);
    chk("single_a_held", 32'(bus.alu_a), 3);
    tick();
    chk("single_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("single_rsp_result", 32'(bus.rsp_result), 8);
    chk("single_rsp_addr", 32'(bus.rsp_addr), 'h11);
    chk("single_rsp_err", 32'(bus.rsp_err), 0);
    tick();
    chk("single_rsp_hold", 32'(bus.rsp_valid), 1);
    chk("single_rsp_hold_res", 32'(bus.rsp_result), 8);
    bus.rsp_ready = 1'b1;
    tick();
    chk("single_popped", 32'(bus.rsp_valid), 0);
    chk("single_idle_busy", 32'(bus.busy), 0);

    // Idle drive
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_opcode", 32'(bus.alu_opcode), NOP_OP);
      chk("idle_tag", 32'(bus.alu_addr_in), 0);
      chk("idle_no_rsp", 32'(bus.rsp_valid), 0);
    end

    // Streaming: cmd k = {a=3k, b=k+1, add, tag k}; result 4k+1
    drive(1, 8'd0, 8'd1, 3'd1, 8'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k < 8) chk("stream_cmd_ready", 32'(bus.cmd_ready), 1);
      if (k >= 4) begin
        chk("stream_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("stream_rsp_addr", 32'(bus.rsp_addr), k - 4);
        chk("stream_rsp_result", 32'(bus.rsp_result), 4 * (k - 4) + 1);
        chk("stream_rsp_err", 32'(bus.rsp_err), 0);
      end
      if (k + 1 < 8) drive(1, 8'((k + 1) * 3), 8'(k + 2), 3'd1, 8'(k + 1));
      else drive(0, 0, 0, 0, 0);
    end
    tick();
    chk("stream_done", 32'(bus.rsp_valid), 0);

    // Backpressure: cmd n = {a=n+1, b=2, mul, tag 0x40+n}; result 2(n+1)
    bus.rsp_ready = 1'b0;
    i_cmd = 0;
    issued = 0;
    drive(1, 8'd1, 8'd2, 3'd2, 8'h40);
    for (int c = 0; c < 20; c++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (bus.alu_opcode != 3'(NOP_OP)) issued++;
      if (acc) begin
        i_cmd++;
        if (i_cmd < 10) drive(1, 8'(i_cmd + 1), 8'd2, 3'd2, 8'(8'h40 + i_cmd));
        else drive(0, 0, 0, 0, 0);
      end
    end
    chk("bp_issued", issued, 4);
    chk("bp_accepted", i_cmd, 8);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_head_tag", 32'(bus.rsp_addr), 'h40);

    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.rsp_valid) begin
        chk("drain_tag", 32'(bus.rsp_addr), 'h40 + n_rsp);
        chk("drain_result", 32'(bus.rsp_result), 2 * (n_rsp + 1));
        n_rsp++;
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) begin
        i_cmd++;
        if (i_cmd < 10) drive(1, 8'(i_cmd + 1), 8'd2, 3'd2, 8'(8'h40 + i_cmd));
        else drive(0, 0, 0, 0, 0);
      end
    end
    chk("drain_count", n_rsp, 10);
    chk("drain_accepted", i_cmd, 10);
    chk("drain_busy", 32'(bus.busy), 0);

    // Tag mismatch on 0x22; cmd j = {a=0x10+j, b=1, add}
    chk("mm_sticky_before", 32'(bus.err_sticky), 0);
    for (int j = 0; j < 3; j++) begin
      drive(1, 8'(8'h10 + j), 8'd1, 3'd1, mm_tag[j]);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_rsp = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid && n_rsp < 3) begin
        chk("mm_addr", 32'(bus.rsp_addr), 32'(mm_tag[n_rsp]));
        chk("mm_result", 32'(bus.rsp_result), 'h11 + n_rsp);
        chk("mm_err", 32'(bus.rsp_err), 32'(mm_err[n_rsp]));
        chk("mm_sticky", 32'(bus.err_sticky), 32'(mm_sticky[n_rsp]));
        n_rsp++;
      end
      tick();
    end
    chk("mm_count", n_rsp, 3);
    chk("mm_sticky_kept", 32'(bus.err_sticky), 1);

    // Reset mid-flight: responses held back, work in FIFO, pipe and buffer
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 8'(c), 8'd3, 3'd1, 8'(8'h60 + c));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("mid_busy", 32'(bus.busy), 1);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 1);
    reset = 1'b1;
    #1;
    chk_reset_values("mid_rst");
    tick();
    reset = 1'b0;
    chk("mid_ready_low", 32'(bus.cmd_ready), 0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("flush_no_rsp", 32'(bus.rsp_valid), 0);
      chk("flush_busy", 32'(bus.busy), 0);
      chk("flush_opcode", 32'(bus.alu_opcode), NOP_OP);
    end
    chk("flush_ready", 32'(bus.cmd_ready), 1);
    chk("flush_sticky", 32'(bus.err_sticky), 0);

    // Normal operation after the flush
    drive(1, 8'd7, 8'd9, 3'd1, 8'h77);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("post_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("post_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("post_rsp_addr", 32'(bus.rsp_addr), 'h77);
    chk("post_rsp_result", 32'(bus.rsp_result), 16);
    chk("post_rsp_err", 32'(bus.rsp_err), 0);
    tick();
    chk("post_idle", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
